// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_data_t  : one fetch-buffer entry {instruction, pc, ex_data}
//   ex_data_t     : exception payload carried alongside a fetched word
//   fetch_state_t : fetch control states (REQ, DRAIN, HALT)
//   pc_misaligned : IALIGN check on the low PC bits
package fetch_unit_pkg;

  localparam logic [63:0] PC_RESET_DEFAULT      = 64'h8000_0000;
  localparam logic [3:0]  INSTR_ADDR_MISALIGNED = 4'd0;

  typedef struct packed {
    logic        exception;
    logic [3:0]  code;
    logic [63:0] value;
  } ex_data_t;

  typedef struct packed {
    logic [31:0] instruction;
    logic [63:0] pc;
    ex_data_t    ex_data;
  } fetch_data_t;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // IALIGN=16 (compressed ISA) only needs pc[0] clear; IALIGN=32 needs pc[1:0].
  function automatic logic pc_misaligned(input logic [1:0] pc_lo, input logic c_ext);
    return c_ext ? pc_lo[0] : (|pc_lo);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer between the fetch control and decode.
//   clk, reset   : clock, synchronous active-high reset
//   flush_i      : drop all entries (wins over push/pop)
//   push_i/push_data_i : enqueue; accepted when not full or when popping
//   pop_i        : dequeue head (ignored when empty)
//   pop_data_o   : current head entry
//   count_o, full_o, empty_o : occupancy
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        push_i,
  input  fetch_data_t push_data_i,
  input  logic        pop_i,
  output fetch_data_t pop_data_o,
  output logic [CW-1:0] count_o,
  output logic        full_o,
  output logic        empty_o
);

  fetch_data_t   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_o;
  // Push at full is only legal together with a pop; occupancy then stays put.
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order across always_ff blocks.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity comes from count_q,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues hold-until-ok bus requests,
// queues fetched words for decode and handles redirects / in-flight discard.
//   clk, reset                : clock, synchronous active-high reset
//   ireq_valid/ireq_addr      : fetch request, held until iresp_ok
//   iresp_ok/iresp_data       : request completion and fetched word
//   redirect_valid/redirect_pc: flush and restart fetch at a new PC
//   out_valid/out_ready/dataF : fetch-buffer head towards decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] PC_RESET   = PC_RESET_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned C_EXT      = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output fetch_data_t dataF
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [63:0]   drain_addr_q, drain_addr_d;  // address of the abandoned request
  logic          req_q, req_d;                // request raised and still waiting
  logic          req_v;

  logic          fifo_push, fifo_flush, fifo_pop, fifo_full, fifo_empty;
  fetch_data_t   fifo_push_data, fifo_head;
  logic [CW-1:0] fifo_count;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drain_addr_d   = drain_addr_q;
    req_d          = 1'b0;
    req_v          = 1'b0;
    fifo_push      = 1'b0;
    fifo_flush     = 1'b0;
    fifo_push_data = '0;

    case (state_q)
      REQ: begin
        if (pc_misaligned(pc_q[1:0], C_EXT != 0)) begin
          if (!fifo_full) begin
            fifo_push                  = 1'b1;
            fifo_push_data.pc          = pc_q;
            fifo_push_data.ex_data     = '{exception: 1'b1,
                                           code:      INSTR_ADDR_MISALIGNED,
                                           value:     pc_q};
            state_d                    = HALT;
          end
        end else begin
          // Room is checked only when the request is first raised; afterwards
          // it is held regardless, which keeps a free slot for its response.
          req_v = req_q || (fifo_count < CW'(FIFO_DEPTH));
          if (req_v && iresp_ok) begin
            fifo_push                  = 1'b1;
            fifo_push_data.instruction = iresp_data;
            fifo_push_data.pc          = pc_q;
            pc_d                       = pc_q + 64'd4;
          end else begin
            req_d = req_v;
          end
        end
      end
      DRAIN: begin
        req_v = 1'b1;
        if (iresp_ok) state_d = REQ;
      end
      HALT: ;
      default: state_d = REQ;
    endcase

    if (redirect_valid) begin
      fifo_flush = 1'b1;
      fifo_push  = 1'b0;
      pc_d       = redirect_pc;
      req_d      = 1'b0;
      if (req_v && !iresp_ok) begin
        state_d = DRAIN;
        // A redirect inside DRAIN keeps the original in-flight address.
        if (state_q == REQ) drain_addr_d = pc_q;
      end else begin
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= REQ;
      pc_q         <= PC_RESET;
      drain_addr_q <= '0;
      req_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      req_q        <= req_d;
    end
  end

  assign ireq_valid = req_v && !reset;
  assign ireq_addr  = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign out_valid  = !fifo_empty && !reset && (state_q != DRAIN);
  assign fifo_pop   = out_valid && out_ready;
  assign dataF      = out_valid ? fifo_head : '0;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (fifo_flush),
    .push_i     (fifo_push),
    .push_data_i(fifo_push_data),
    .pop_i      (fifo_pop),
    .pop_data_o (fifo_head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one IALIGN=32 instance exercised in full and
// an IALIGN=16 instance used for the compressed-alignment case.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk, reset;
  logic        ireq_valid, iresp_ok, redirect_valid, out_valid, out_ready;
  logic [63:0] ireq_addr, redirect_pc;
  logic [31:0] iresp_data;
  fetch_data_t data_f;

  logic        ireq_valid1, iresp_ok1, redirect_valid1, out_valid1;
  logic [63:0] ireq_addr1;
  fetch_data_t data_f1;

  int passed = 0;
  int total  = 0;

  fetch_unit #(.C_EXT(0)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_ok(iresp_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .dataF(data_f)
  );

  fetch_unit #(.C_EXT(1)) dut_c (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid1), .ireq_addr(ireq_addr1),
    .iresp_ok(iresp_ok1), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc),
    .out_valid(out_valid1), .out_ready(1'b0), .dataF(data_f1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs change at the falling edge; checks run #1 later, far from posedge.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; iresp_ok = 1'b0; iresp_data = '0; redirect_valid = 1'b0;
    redirect_pc = '0; out_ready = 1'b0; iresp_ok1 = 1'b0; redirect_valid1 = 1'b0;
    nxt(); nxt();
    #1;
    check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_dataF_zero", 64'(|data_f),    64'd0);

    // Back-to-back fetch with same-cycle ok and decode always ready.
    nxt(); reset = 1'b0; out_ready = 1'b1; iresp_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) nxt();
      iresp_data = 32'hA000_0000 + 32'(i);
      #1;
      check("stream_ireq_valid", 64'(ireq_valid), 64'd1);
      check("stream_ireq_addr",  ireq_addr, 64'h8000_0000 + 64'(4 * i));
      if (i > 0) begin
        check("stream_out_valid", 64'(out_valid), 64'd1);
        check("stream_pc",        data_f.pc, 64'h8000_0000 + 64'(4 * (i - 1)));
        check("stream_insn",      64'(data_f.instruction), 64'hA000_0000 + 64'(i - 1));
      end
    end
    nxt(); #1;
    check("stream_last_pc", data_f.pc, 64'h8000_0008);
    check("stream_ex_zero", 64'(|data_f.ex_data), 64'd0);

    // Fill the buffer with decode stalled, then release a single slot.
    nxt(); reset = 1'b1; iresp_ok = 1'b0; out_ready = 1'b0;
    nxt(); reset = 1'b0; iresp_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) nxt();
      iresp_data = 32'hB000_0000 + 32'(k);
      #1;
      check("fill_ireq_valid", 64'(ireq_valid), 64'd1);
      check("fill_ireq_addr",  ireq_addr, 64'h8000_0000 + 64'(4 * k));
    end
    nxt(); #1;
    check("full_no_req",   64'(ireq_valid), 64'd0);
    check("full_head_pc",  data_f.pc, 64'h8000_0000);
    nxt(); out_ready = 1'b1; #1;
    check("full_still_no_req", 64'(ireq_valid), 64'd0);
    check("full_head_insn",    64'(data_f.instruction), 64'hB000_0000);
    nxt(); out_ready = 1'b0; #1;
    check("pop_new_req",      64'(ireq_valid), 64'd1);
    check("pop_new_req_addr", ireq_addr, 64'h8000_0010);
    check("pop_head_pc",      data_f.pc, 64'h8000_0004);
    nxt(); #1;
    check("refull_no_req", 64'(ireq_valid), 64'd0);

    // Redirect while a request is outstanding: its response must be dropped.
    nxt(); reset = 1'b1; iresp_ok = 1'b0;
    nxt(); reset = 1'b0; iresp_ok = 1'b1; out_ready = 1'b1; iresp_data = 32'h1111_1111;
    nxt();
    nxt(); iresp_ok = 1'b0; #1;
    check("inflight_addr", ireq_addr, 64'h8000_0008);
    nxt(); redirect_valid = 1'b1; redirect_pc = 64'h8000_1000; #1;
    check("redir_hold_valid", 64'(ireq_valid), 64'd1);
    nxt(); redirect_valid = 1'b0; #1;
    check("drain_valid",     64'(ireq_valid), 64'd1);
    check("drain_old_addr",  ireq_addr, 64'h8000_0008);
    check("drain_out_valid", 64'(out_valid), 64'd0);
    nxt();
    nxt(); iresp_ok = 1'b1; iresp_data = 32'hDEAD_BEEF; #1;
    check("drain_ok_addr", ireq_addr, 64'h8000_0008);
    nxt(); iresp_ok = 1'b0; #1;
    check("drain_discarded", 64'(out_valid), 64'd0);
    check("drain_new_valid", 64'(ireq_valid), 64'd1);
    check("drain_new_addr",  ireq_addr, 64'h8000_1000);

    // Redirect coinciding with iresp_ok: word dropped, no drain.
    nxt(); iresp_ok = 1'b1; iresp_data = 32'hCAFE_F00D;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
    nxt(); iresp_ok = 1'b0; redirect_valid = 1'b0; #1;
    check("coinc_valid",     64'(ireq_valid), 64'd1);
    check("coinc_addr",      ireq_addr, 64'h8000_3000);
    check("coinc_out_valid", 64'(out_valid), 64'd0);

    // Misaligned target (IALIGN=32) versus the same target with IALIGN=16.
    nxt(); iresp_ok = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_1002;
    iresp_ok1 = 1'b1; redirect_valid1 = 1'b1;
    nxt(); iresp_ok = 1'b0; redirect_valid = 1'b0; iresp_ok1 = 1'b0; redirect_valid1 = 1'b0; #1;
    check("mis_no_req",   64'(ireq_valid), 64'd0);
    check("cext_req",     64'(ireq_valid1), 64'd1);
    check("cext_addr",    ireq_addr1, 64'h8000_1002);
    nxt(); #1;
    check("mis_out_valid", 64'(out_valid), 64'd1);
    check("mis_pc",        data_f.pc, 64'h8000_1002);
    check("mis_insn",      64'(data_f.instruction), 64'd0);
    check("mis_exc",       64'(data_f.ex_data.exception), 64'd1);
    check("mis_code",      64'(data_f.ex_data.code), 64'(INSTR_ADDR_MISALIGNED));
    check("mis_value",     data_f.ex_data.value, 64'h8000_1002);
    nxt(); #1;
    check("halt_no_req",   64'(ireq_valid), 64'd0);
    check("halt_no_dup",   64'(out_valid), 64'd0);
    nxt(); redirect_valid = 1'b1; redirect_pc = 64'h8000_2000; #1;
    check("halt_redir_no_req", 64'(ireq_valid), 64'd0);
    nxt(); redirect_valid = 1'b0; out_ready = 1'b0; iresp_ok = 1'b1; iresp_data = 32'h2222_0000; #1;
    check("resume_addr", ireq_addr, 64'h8000_2000);
    nxt(); iresp_data = 32'h2222_0004; #1;
    check("resume_addr2", ireq_addr, 64'h8000_2004);

    // Reset with a live request and two buffered entries.
    nxt(); iresp_ok = 1'b0; #1;
    check("pre_rst_head", data_f.pc, 64'h8000_2000);
    check("pre_rst_req",  64'(ireq_valid), 64'd1);
    nxt(); reset = 1'b1; #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_ireq",      64'(ireq_valid), 64'd0);
    check("midrst_dataF",     64'(|data_f), 64'd0);
    nxt(); reset = 1'b0; #1;
    check("postrst_ireq",      64'(ireq_valid), 64'd1);
    check("postrst_addr",      ireq_addr, 64'h8000_0000);
    check("postrst_out_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Sequential instruction-fetch stage.
- Owns the PC register and drives the instruction bus with a hold-until-ok request handshake.
- Buffers fetched words in a FIFO_DEPTH-entry queue that feeds decode.
- Handles redirects/flushes, including discarding an in-flight response. Raises the instruction-address-misaligned exception per the IALIGN mode.

Parameters:
PC_RESET, 64'h8000_0000, PC value loaded on reset
FIFO_DEPTH, 4, fetch-buffer entries (power of two, >=2)
C_EXT, 0, 0: IALIGN=32, check pc[1:0]; 1: IALIGN=16, check pc[0] only

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ireq_valid  out  1  fetch request valid; held until iresp_ok
ireq_addr  out  64  fetch address; stable while ireq_valid && !iresp_ok
iresp_ok  in  1  request complete; iresp_data valid this cycle
iresp_data  in  32  fetched instruction word
redirect_valid  in  1  flush and restart fetch (branch/exception/mret)
redirect_pc  in  64  new fetch PC
out_valid  out  1  FIFO head valid
out_ready  in  1  decode accepts head
dataF  out  fetch_data_t  {instruction, pc, ex_data} of FIFO head

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset (sampled at the clk edge):
  - pc <= PC_RESET; FIFO empty; state <= REQ.
  - ireq_valid=0, out_valid=0, dataF='0 during the reset cycle.
- States:
  - REQ: normal fetch.
  - DRAIN: an in-flight response must be discarded.
  - HALT: misaligned PC was reported; wait for redirect.
- REQ:
  - If pc is misaligned: no bus request. When count<FIFO_DEPTH, push the entry {instruction=0, pc, ex_data={exception=1, code=INSTR_ADDR_MISALIGNED, value=pc}} and go to HALT.
  - If pc is aligned: ireq_valid=1, ireq_addr=pc, asserted only when count<FIFO_DEPTH at first assertion. Once asserted, it is held until iresp_ok regardless of count.
  - On iresp_ok: push {iresp_data, pc, ex_data='0}; pc <= pc+4. The next request is raised the following cycle at the earliest.
  - Throughput is 1 word/cycle when iresp_ok is same-cycle.
- FIFO:
  - Registered with no bypass: a push at edge t makes out_valid=1 from t+1.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop at full is legal only because issue is gated; the count stays unchanged.
- redirect_valid (priority over everything except reset):
  - FIFO cleared at the edge; any same-cycle push is dropped; pc <= redirect_pc.
  - If ireq_valid && !iresp_ok that cycle: go to DRAIN.
  - Otherwise go to REQ. If iresp_ok coincides with the redirect, the data is discarded and no drain occurs.
- DRAIN:
  - Keep ireq_valid=1 with the old latched address until iresp_ok. Discard the data, then go to REQ with the latched redirect pc.
  - A redirect during DRAIN overwrites the target pc and stays in DRAIN. If it coincides with iresp_ok, go to REQ at the new target.
  - out_valid=0 throughout.
- HALT:
  - No requests. The FIFO continues to drain to decode.
  - Only redirect leaves HALT (to REQ or DRAIN per the rule above; normally REQ).
- pc+4 wraps modulo 2^64 silently.
- Reset mid-request: the bus is abandoned. The bus side is reset in the same domain, so no drain is needed.

Decomposition:
- pipes package: fetch_data_t (existing); add fetch_state_t enum {REQ, DRAIN, HALT}.
- common package: PC_RESET default and INSTR_ADDR_MISALIGNED code.
- One sub-module: fetch_fifo, a parametrised synchronous FIFO with push/pop/flush, count, full/empty, data typed fetch_data_t.

Test Plan:
- Reset, then iresp_ok every cycle, out_ready=1 -> requests at 0x8000_0000, 0x8000_0004, 0x8000_0008; dataF.pc matches one cycle after each ok; ex_data=0.
- out_ready=0, FIFO_DEPTH=4, ok every cycle -> exactly 4 pushes, then ireq_valid stays 0. One pop -> one new request at pc 0x8000_0010.
- Request at 0x8000_0008 outstanding, redirect to 0x8000_1000, iresp_ok 3 cycles later with data 0xDEADBEEF -> word discarded, FIFO empty, next ireq_addr=0x8000_1000.
- Redirect in the same cycle as iresp_ok -> word dropped, no DRAIN, next cycle ireq_addr=redirect_pc.
- Redirect to 0x8000_1002 with C_EXT=0 -> no bus request; entry pc=0x8000_1002, code=INSTR_ADDR_MISALIGNED, value=0x8000_1002; HALT until redirect to 0x8000_2000 resumes fetch. With C_EXT=1, 0x8000_1002 is fetched normally.
- Reset asserted while ireq_valid=1 and FIFO holds 2 entries -> next cycle out_valid=0, ireq_valid=0; the cycle after, ireq_addr=PC_RESET.
